// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache refill path.
//   refill_slot_state_e : per-slot lifecycle FREE -> AR_PEND -> DATA -> DONE
//   refill_slot_t       : reference slot record at the default geometry
//   AXI_RESP_*          : AXI error response encodings
//   resp_is_err()       : true for SLVERR/DECERR
package wt_cache_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_AR_PEND = 2'd1,
    SLOT_DATA    = 2'd2,
    SLOT_DONE    = 2'd3
  } refill_slot_state_e;

  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned REFILL_PLEN_W    = 56;
  localparam int unsigned REFILL_TID_W     = 2;
  localparam int unsigned REFILL_BEATCNT_W = 8;
  localparam int unsigned REFILL_LINE_W    = 128;

  typedef struct packed {
    logic [REFILL_PLEN_W-1:0]    paddr;
    logic                        nc;
    logic [REFILL_TID_W-1:0]     tid;
    logic [REFILL_BEATCNT_W-1:0] beatcnt;
    logic                        err;
    logic [REFILL_LINE_W-1:0]    data;
  } refill_slot_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/icache_refill_slot.sv
// One refill reassembly slot: state machine plus line buffer.
// Ports:
//   alloc_i/paddr_i/nc_i/tid_i : claim a FREE slot and latch the request
//   ar_done_i                  : this slot's AR handshake completed
//   beat_*                     : R beat routed to this slot (only acted on in DATA)
//   ret_i                      : line return handshake for this slot
//   state_o, paddr_o, nc_o, tid_o, err_o, data_o : slot record
module icache_refill_slot
  import wt_cache_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned PlenWidth    = 56,
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned TidWidth     = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    alloc_i,
  input  logic [PlenWidth-1:0]    paddr_i,
  input  logic                    nc_i,
  input  logic [TidWidth-1:0]     tid_i,
  input  logic                    ar_done_i,
  input  logic                    beat_i,
  input  logic [AxiDataWidth-1:0] beat_data_i,
  input  logic                    beat_last_i,
  input  logic                    beat_err_i,
  input  logic                    ret_i,
  output refill_slot_state_e      state_o,
  output logic [PlenWidth-1:0]    paddr_o,
  output logic                    nc_o,
  output logic [TidWidth-1:0]     tid_o,
  output logic                    err_o,
  output logic [LineWidth-1:0]    data_o
);

  localparam int unsigned NumBeats = LineWidth / AxiDataWidth;
  localparam int unsigned BcW      = $clog2(NumBeats + 1);

  refill_slot_state_e   state_q;
  logic [PlenWidth-1:0] paddr_q;
  logic                 nc_q;
  logic [TidWidth-1:0]  tid_q;
  logic [BcW-1:0]       beatcnt_q;
  logic                 err_q;
  logic [LineWidth-1:0] data_q;
  logic                 final_beat;

  assign final_beat = nc_q | (beatcnt_q == BcW'(NumBeats - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SLOT_FREE;
      paddr_q   <= '0;
      nc_q      <= 1'b0;
      tid_q     <= '0;
      beatcnt_q <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else if (clr_i) begin
      state_q   <= SLOT_FREE;
      paddr_q   <= '0;
      nc_q      <= 1'b0;
      tid_q     <= '0;
      beatcnt_q <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      case (state_q)
        SLOT_FREE: if (alloc_i) begin
          state_q   <= SLOT_AR_PEND;
          paddr_q   <= paddr_i;
          nc_q      <= nc_i;
          tid_q     <= tid_i;
          beatcnt_q <= '0;
          err_q     <= 1'b0;
          // Cleared up front so nc fills and truncated bursts leave zeros.
          data_q    <= '0;
        end
        SLOT_AR_PEND: if (ar_done_i) state_q <= SLOT_DATA;
        SLOT_DATA: if (beat_i) begin
          if (nc_q) begin
            data_q <= LineWidth'(beat_data_i);
          end else begin
            for (int unsigned b = 0; b < NumBeats; b++) begin
              if (beatcnt_q == BcW'(b)) data_q[b*AxiDataWidth +: AxiDataWidth] <= beat_data_i;
            end
          end
          beatcnt_q <= beatcnt_q + 1'b1;
          if (beat_err_i) err_q <= 1'b1;
          if (final_beat) begin
            state_q <= SLOT_DONE;
          end else if (beat_last_i) begin
            // Burst truncated by the interconnect: line is incomplete.
            state_q <= SLOT_DONE;
            err_q   <= 1'b1;
          end
        end
        SLOT_DONE: if (ret_i) state_q <= SLOT_FREE;
        default: state_q <= SLOT_FREE;
      endcase
    end
  end

  assign state_o = state_q;
  assign paddr_o = paddr_q;
  assign nc_o    = nc_q;
  assign tid_o   = tid_q;
  assign err_o   = err_q;
  assign data_o  = data_q;

endmodule

// File: rtl/icache_axi_refill_adapter.sv
// I-cache refill engine: turns line-fill / non-cacheable fetch requests into
// AXI read bursts and reassembles R beats into full lines, with up to
// NumOutstanding bursts in flight (AXI ID = slot index).
// Ports: req_* (request in), ar_* (AXI AR out), r_* (AXI R in),
//        rtrn_* (line return out), proto_err_o (sticky stray-beat flag),
//        burst_cnt_o / err_cnt_o (perf counters).
// Optional: define ICACHE_REFILL_PERF_CNT_EN to build the saturating perf
// counters; otherwise burst_cnt_o/err_cnt_o are tied to zero.
module icache_axi_refill_adapter
  import wt_cache_pkg::*;
#(
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned PlenWidth      = 56,
  parameter int unsigned LineWidth      = 128,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned NumOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [PlenWidth-1:0]    req_paddr_i,
  input  logic                    req_nc_i,
  input  logic [TidWidth-1:0]     req_tid_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AxiAddrWidth-1:0] ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [AxiIdWidth-1:0]   ar_id_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [AxiDataWidth-1:0] r_data_i,
  input  logic [AxiIdWidth-1:0]   r_id_i,
  input  logic                    r_last_i,
  input  logic [1:0]              r_resp_i,
  output logic                    rtrn_valid_o,
  input  logic                    rtrn_ready_i,
  output logic [LineWidth-1:0]    rtrn_data_o,
  output logic [TidWidth-1:0]     rtrn_tid_o,
  output logic                    rtrn_err_o,
  output logic                    proto_err_o,
  output logic [31:0]             burst_cnt_o,
  output logic [31:0]             err_cnt_o
);

  localparam int unsigned IdxW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam logic [AxiAddrWidth-1:0] LineMask = AxiAddrWidth'(LineWidth / 8 - 1);
  localparam logic [AxiAddrWidth-1:0] BeatMask = AxiAddrWidth'(AxiDataWidth / 8 - 1);
  localparam logic [7:0]              LineLen  = 8'(LineWidth / AxiDataWidth - 1);
  localparam logic [2:0]              ArSize   = 3'($clog2(AxiDataWidth / 8));

  refill_slot_state_e   slot_state [NumOutstanding];
  logic [PlenWidth-1:0] slot_paddr [NumOutstanding];
  logic [TidWidth-1:0]  slot_tid   [NumOutstanding];
  logic [LineWidth-1:0] slot_data  [NumOutstanding];
  logic [NumOutstanding-1:0] slot_nc, slot_err;
  logic [NumOutstanding-1:0] slot_alloc, slot_ar_done, slot_beat, slot_ret;

  logic                    ar_valid_q;
  logic [IdxW-1:0]         ar_id_q;
  logic                    rtrn_valid_q;
  logic [IdxW-1:0]         rtrn_slot_q;
  logic [IdxW-1:0]         rr_last_q;
  logic                    any_free, accept, ar_hs, stray, beat_err;
  logic [IdxW-1:0]         alloc_idx;
  logic                    gnt_valid;
  logic [IdxW-1:0]         gnt_idx;
  logic [AxiAddrWidth-1:0] ar_paddr;

  // Lowest-index FREE slot; based on registered state, so a slot released
  // this cycle only becomes visible next cycle.
  always_comb begin
    any_free  = 1'b0;
    alloc_idx = '0;
    for (int unsigned i = NumOutstanding; i > 0; i--) begin
      if (slot_state[i-1] == SLOT_FREE) begin
        any_free  = 1'b1;
        alloc_idx = IdxW'(i - 1);
      end
    end
  end

  assign req_ready_o = any_free & ~ar_valid_q;
  assign accept      = req_valid_i & req_ready_o;
  assign ar_hs       = ar_valid_q & ar_ready_i;
  assign beat_err    = resp_is_err(r_resp_i);
  assign r_ready_o   = 1'b1;

  always_comb begin
    for (int unsigned i = 0; i < NumOutstanding; i++) begin
      slot_alloc[i]   = accept & (alloc_idx == IdxW'(i));
      slot_ar_done[i] = ar_hs & (ar_id_q == IdxW'(i));
      slot_beat[i]    = r_valid_i & (r_id_i == AxiIdWidth'(i)) & (slot_state[i] == SLOT_DATA);
      slot_ret[i]     = rtrn_valid_q & rtrn_ready_i & (rtrn_slot_q == IdxW'(i));
    end
  end

  assign stray = r_valid_i & ~(|slot_beat);

  for (genvar g = 0; g < NumOutstanding; g++) begin : gen_slot
    icache_refill_slot #(
      .AxiDataWidth(AxiDataWidth),
      .PlenWidth   (PlenWidth),
      .LineWidth   (LineWidth),
      .TidWidth    (TidWidth)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (clr_i),
      .alloc_i    (slot_alloc[g]),
      .paddr_i    (req_paddr_i),
      .nc_i       (req_nc_i),
      .tid_i      (req_tid_i),
      .ar_done_i  (slot_ar_done[g]),
      .beat_i     (slot_beat[g]),
      .beat_data_i(r_data_i),
      .beat_last_i(r_last_i),
      .beat_err_i (beat_err),
      .ret_i      (slot_ret[g]),
      .state_o    (slot_state[g]),
      .paddr_o    (slot_paddr[g]),
      .nc_o       (slot_nc[g]),
      .tid_o      (slot_tid[g]),
      .err_o      (slot_err[g]),
      .data_o     (slot_data[g])
    );
  end

  // AR fields come straight from the pending slot's latched record, so they
  // stay stable for as long as ar_valid_o is held.
  always_comb begin
    ar_paddr                  = '0;
    ar_paddr[PlenWidth-1:0]   = slot_paddr[ar_id_q];
    ar_addr_o                 = '0;
    ar_len_o                  = '0;
    ar_size_o                 = '0;
    if (ar_valid_q) begin
      ar_size_o = ArSize;
      if (slot_nc[ar_id_q]) begin
        ar_addr_o = ar_paddr & ~BeatMask;
      end else begin
        ar_addr_o = ar_paddr & ~LineMask;
        ar_len_o  = LineLen;
      end
    end
  end

  assign ar_valid_o = ar_valid_q;
  assign ar_id_o    = AxiIdWidth'(ar_id_q);

  // Round-robin over DONE slots, starting after the last granted index.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 1; k <= NumOutstanding; k++) begin
      if (!gnt_valid && slot_state[(32'(rr_last_q) + k) % NumOutstanding] == SLOT_DONE) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'((32'(rr_last_q) + k) % NumOutstanding);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_valid_q   <= 1'b0;
      ar_id_q      <= '0;
      rtrn_valid_q <= 1'b0;
      rtrn_slot_q  <= '0;
      rr_last_q    <= IdxW'(NumOutstanding - 1);
      rtrn_data_o  <= '0;
      rtrn_tid_o   <= '0;
      rtrn_err_o   <= 1'b0;
      proto_err_o  <= 1'b0;
    end else if (clr_i) begin
      ar_valid_q   <= 1'b0;
      ar_id_q      <= '0;
      rtrn_valid_q <= 1'b0;
      rtrn_slot_q  <= '0;
      rr_last_q    <= IdxW'(NumOutstanding - 1);
      rtrn_data_o  <= '0;
      rtrn_tid_o   <= '0;
      rtrn_err_o   <= 1'b0;
      proto_err_o  <= 1'b0;
    end else begin
      if (accept) begin
        ar_valid_q <= 1'b1;
        ar_id_q    <= alloc_idx;
      end else if (ar_hs) begin
        ar_valid_q <= 1'b0;
      end
      if (stray) proto_err_o <= 1'b1;
      // The presented slot stays DONE until its handshake, so new grants are
      // only taken while the return register is empty.
      if (rtrn_valid_q) begin
        if (rtrn_ready_i) rtrn_valid_q <= 1'b0;
      end else if (gnt_valid) begin
        rtrn_valid_q <= 1'b1;
        rtrn_slot_q  <= gnt_idx;
        rr_last_q    <= gnt_idx;
        rtrn_data_o  <= slot_data[gnt_idx];
        rtrn_tid_o   <= slot_tid[gnt_idx];
        rtrn_err_o   <= slot_err[gnt_idx];
      end
    end
  end

  assign rtrn_valid_o = rtrn_valid_q;

`ifdef ICACHE_REFILL_PERF_CNT_EN
  logic [31:0] burst_cnt_q, err_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      burst_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (clr_i) begin
      burst_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (ar_hs && burst_cnt_q != '1) burst_cnt_q <= burst_cnt_q + 32'd1;
      if (r_valid_i && beat_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end
  assign burst_cnt_o = burst_cnt_q;
  assign err_cnt_o   = err_cnt_q;
`else
  assign burst_cnt_o = '0;
  assign err_cnt_o   = '0;
`endif

endmodule
